// File: rtl/monitor_conflicte_if.sv
// Lamp bus between the traffic controller, the conflict monitor and the field drivers.
// The slave side is the monitor; the master side drives raw lamp requests and reads the field outputs.
interface monitor_conflicte_if;
    logic [3:0] verde_i;
    logic [3:0] galben_i;
    logic [3:0] rosu_i;
    logic [3:0] verde_pietoni_i;
    logic [3:0] rosu_pietoni_i;
    logic       ack_i;
    logic [3:0] verde_o;
    logic [3:0] galben_o;
    logic [3:0] rosu_o;
    logic [3:0] verde_pietoni_o;
    logic [3:0] rosu_pietoni_o;
    logic       fault_o;
    logic [2:0] cod_fault_o;
    logic [7:0] nr_fault_o;

    modport slave (
        input  verde_i, galben_i, rosu_i, verde_pietoni_i, rosu_pietoni_i, ack_i,
        output verde_o, galben_o, rosu_o, verde_pietoni_o, rosu_pietoni_o,
        output fault_o, cod_fault_o, nr_fault_o
    );

    modport master (
        output verde_i, galben_i, rosu_i, verde_pietoni_i, rosu_pietoni_i, ack_i,
        input  verde_o, galben_o, rosu_o, verde_pietoni_o, rosu_pietoni_o,
        input  fault_o, cod_fault_o, nr_fault_o
    );
endinterface

// File: rtl/monitor_conflicte.sv
// Traffic-light conflict monitor: filters lamp conflicts through a persistence counter,
// latches a fault code and forces flashing yellow / all-red on the field until acknowledged.
module monitor_conflicte #(
    parameter int FACTOR_DIVIZARE = 1000,
    parameter int PERSISTENTA     = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    monitor_conflicte_if.slave   bus
);

    localparam int                DIV_W     = $clog2(FACTOR_DIVIZARE);
    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(FACTOR_DIVIZARE - 1);
    localparam logic [7:0]        PERS_LAST = 8'(PERSISTENTA - 1);

    typedef enum logic [1:0] {
        NORMAL  = 2'd0,
        SUSPECT = 2'd1,
        FAULT   = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [7:0]       cnt_q, cnt_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic             phase_q, phase_d;
    logic [2:0]       cod_q, cod_d;
    logic [7:0]       nr_q, nr_d;
    logic [3:0]       verde_q, galben_q, rosu_q, vp_q, rp_q;
    logic [3:0]       verde_d, galben_d, rosu_d, vp_d, rp_d;

    logic             e1, e2, e3, e4, err, entering;
    logic [2:0]       nr_green;
    logic [2:0]       code;

    function automatic logic [7:0] sat_inc(input logic [7:0] x);
        return (x == 8'd255) ? x : x + 8'd1;
    endfunction

    function automatic logic [2:0] prio_code(input logic a, input logic b,
                                             input logic c, input logic d);
        if (a)      return 3'd1;
        else if (b) return 3'd2;
        else if (c) return 3'd3;
        else if (d) return 3'd4;
        else        return 3'd0;
    endfunction

    // Conflict detection on raw inputs, one lamp group per approach
    always_comb begin
        nr_green = 3'd0;
        e2       = 1'b0;
        e3       = 1'b0;
        e4       = 1'b0;
        for (int k = 0; k < 4; k++) begin
            nr_green = nr_green + 3'(bus.verde_i[k]);
            if ((2'(bus.verde_i[k]) + 2'(bus.galben_i[k]) + 2'(bus.rosu_i[k])) != 2'd1)
                e2 = 1'b1;
            if (bus.verde_pietoni_i[k] == bus.rosu_pietoni_i[k])
                e3 = 1'b1;
            if (bus.verde_pietoni_i[k] && (bus.verde_i[k] || bus.galben_i[k]))
                e4 = 1'b1;
        end
        e1   = (nr_green >= 3'd2);
        code = prio_code(e1, e2, e3, e4);
        err  = (code != 3'd0);
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= NORMAL;
            cnt_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            NORMAL: begin
                if (err) begin
                    if (PERSISTENTA == 1) begin
                        state_d = FAULT;
                        cnt_d   = 8'd0;
                    end else begin
                        state_d = SUSPECT;
                        cnt_d   = 8'd1;
                    end
                end
            end
            SUSPECT: begin
                if (!err) begin
                    state_d = NORMAL;
                    cnt_d   = 8'd0;
                end else if (cnt_q == PERS_LAST) begin
                    state_d = FAULT;
                    cnt_d   = 8'd0;
                end else begin
                    cnt_d   = cnt_q + 8'd1;
                end
            end
            FAULT: begin
                if (bus.ack_i && !err)
                    state_d = NORMAL;
            end
            default: begin
                state_d = NORMAL;
                cnt_d   = 8'd0;
            end
        endcase
    end

    // Output logic: next contents of the lamp, flash and fault bookkeeping registers
    always_comb begin
        entering = (state_d == FAULT) && (state_q != FAULT);
        div_d    = '0;
        phase_d  = 1'b1;
        cod_d    = cod_q;
        nr_d     = nr_q;
        verde_d  = bus.verde_i;
        galben_d = bus.galben_i;
        rosu_d   = bus.rosu_i;
        vp_d     = bus.verde_pietoni_i;
        rp_d     = bus.rosu_pietoni_i;
        if (state_d == FAULT) begin
            if (entering) begin
                cod_d = code;
                nr_d  = sat_inc(nr_q);
            end else if (div_q == DIV_LAST) begin
                phase_d = ~phase_q;
            end else begin
                div_d   = div_q + 1'b1;
                phase_d = phase_q;
            end
            verde_d  = 4'h0;
            galben_d = phase_d ? 4'hF : 4'h0;
            rosu_d   = 4'h0;
            vp_d     = 4'h0;
            rp_d     = 4'hF;
        end
    end

    // Output registers; reset drives the field to a safe all-red picture
    always_ff @(posedge clk) begin
        if (rst) begin
            div_q    <= '0;
            phase_q  <= 1'b1;
            cod_q    <= 3'd0;
            nr_q     <= 8'd0;
            verde_q  <= 4'h0;
            galben_q <= 4'h0;
            rosu_q   <= 4'hF;
            vp_q     <= 4'h0;
            rp_q     <= 4'hF;
        end else begin
            div_q    <= div_d;
            phase_q  <= phase_d;
            cod_q    <= cod_d;
            nr_q     <= nr_d;
            verde_q  <= verde_d;
            galben_q <= galben_d;
            rosu_q   <= rosu_d;
            vp_q     <= vp_d;
            rp_q     <= rp_d;
        end
    end

    assign bus.verde_o         = verde_q;
    assign bus.galben_o        = galben_q;
    assign bus.rosu_o          = rosu_q;
    assign bus.verde_pietoni_o = vp_q;
    assign bus.rosu_pietoni_o  = rp_q;
    assign bus.fault_o         = (state_q == FAULT);
    assign bus.cod_fault_o     = (state_q == FAULT) ? cod_q : 3'd0;
    assign bus.nr_fault_o      = nr_q;

endmodule

// File: tb/tb_monitor_conflicte.sv
// Scoreboard bench for monitor_conflicte with PERSISTENTA=3, FACTOR_DIVIZARE=4.
// The driver queues the hand-computed response for each cycle; the monitor checks it after the edge.
module tb_monitor_conflicte;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    monitor_conflicte_if bus();

    monitor_conflicte #(
        .FACTOR_DIVIZARE(4),
        .PERSISTENTA(3)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    typedef struct {
        logic [3:0] v, g, r, vp, rp;
        logic       f;
        logic [2:0] c;
        logic [7:0] n;
        string      name;
    } item_t;

    item_t exp_q[$];
    int    n_cmp = 0;
    int    n_bad = 0;

    localparam logic [3:0] GAL_SEQ [9] = '{4'hF, 4'hF, 4'hF, 4'h0, 4'h0, 4'h0, 4'h0, 4'hF, 4'hF};

    task automatic drive(input logic r_, input logic [3:0] v, g, r, vp, rp, input logic ack);
        @(negedge clk);
        rst                 = r_;
        bus.verde_i         = v;
        bus.galben_i        = g;
        bus.rosu_i          = r;
        bus.verde_pietoni_i = vp;
        bus.rosu_pietoni_i  = rp;
        bus.ack_i           = ack;
    endtask

    task automatic expect_out(input logic [3:0] v, g, r, vp, rp, input logic f,
                              input logic [2:0] c, input logic [7:0] n, input string nm);
        item_t it;
        it.v = v; it.g = g; it.r = r; it.vp = vp; it.rp = rp;
        it.f = f; it.c = c; it.n = n; it.name = nm;
        exp_q.push_back(it);
    endtask

    task automatic pass_step(input logic [3:0] v, g, r, vp, rp, input logic ack,
                             input logic [7:0] n, input string nm);
        drive(1'b0, v, g, r, vp, rp, ack);
        expect_out(v, g, r, vp, rp, 1'b0, 3'd0, n, nm);
    endtask

    task automatic flt_step(input logic [3:0] v, g, r, vp, rp, input logic ack,
                            input logic [3:0] gal, input logic [2:0] c,
                            input logic [7:0] n, input string nm);
        drive(1'b0, v, g, r, vp, rp, ack);
        expect_out(4'h0, gal, 4'h0, 4'h0, 4'hF, 1'b1, c, n, nm);
    endtask

    task automatic rst_step(input logic [3:0] v, g, r, vp, rp, input string nm);
        drive(1'b1, v, g, r, vp, rp, 1'b0);
        expect_out(4'h0, 4'h0, 4'hF, 4'h0, 4'hF, 1'b0, 3'd0, 8'd0, nm);
    endtask

    // Monitor: one registered output picture per clock edge
    initial begin
        item_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_cmp++;
                if ({bus.verde_o, bus.galben_o, bus.rosu_o, bus.verde_pietoni_o, bus.rosu_pietoni_o,
                     bus.fault_o, bus.cod_fault_o, bus.nr_fault_o} !==
                    {e.v, e.g, e.r, e.vp, e.rp, e.f, e.c, e.n}) begin
                    n_bad++;
                    $display("FAIL %s: got v=%h g=%h r=%h vp=%h rp=%h f=%b c=%0d n=%0d, want v=%h g=%h r=%h vp=%h rp=%h f=%b c=%0d n=%0d",
                             e.name, bus.verde_o, bus.galben_o, bus.rosu_o, bus.verde_pietoni_o,
                             bus.rosu_pietoni_o, bus.fault_o, bus.cod_fault_o, bus.nr_fault_o,
                             e.v, e.g, e.r, e.vp, e.rp, e.f, e.c, e.n);
                end
            end
        end
    end

    initial begin
        logic [7:0] nprev, ncur;
        bus.verde_i = 4'h0; bus.galben_i = 4'h0; bus.rosu_i = 4'hF;
        bus.verde_pietoni_i = 4'h0; bus.rosu_pietoni_i = 4'hF; bus.ack_i = 1'b0;

        // Reset picture, then clean pass-through
        rst_step(4'h1, 4'h0, 4'hE, 4'h2, 4'hD, "reset0");
        rst_step(4'h1, 4'h0, 4'hE, 4'h2, 4'hD, "reset1");
        pass_step(4'h1, 4'h0, 4'hE, 4'h2, 4'hD, 1'b0, 8'd0, "legal_a");
        pass_step(4'h0, 4'h4, 4'hB, 4'h1, 4'hE, 1'b0, 8'd0, "legal_b");

        // Two-cycle conflict glitch is filtered, twice in a row
        for (int k = 0; k < 2; k++) begin
            pass_step(4'h3, 4'h0, 4'hC, 4'h0, 4'hF, 1'b0, 8'd0, "glitch_1");
            pass_step(4'h3, 4'h0, 4'hC, 4'h0, 4'hF, 1'b0, 8'd0, "glitch_2");
            pass_step(4'h1, 4'h0, 4'hE, 4'h2, 4'hD, 1'b0, 8'd0, "glitch_end");
        end

        // Held green conflict latches code 1 on the third edge, then flashes 4 on / 4 off
        pass_step(4'h3, 4'h0, 4'hC, 4'h0, 4'hF, 1'b0, 8'd0, "conf_1");
        pass_step(4'h3, 4'h0, 4'hC, 4'h0, 4'hF, 1'b0, 8'd0, "conf_2");
        flt_step(4'h3, 4'h0, 4'hC, 4'h0, 4'hF, 1'b0, 4'hF, 3'd1, 8'd1, "conf_entry");
        for (int k = 1; k <= 9; k++)
            flt_step(4'h3, 4'h0, 4'hC, 4'h0, 4'hF, (k >= 8), GAL_SEQ[k-1], 3'd1, 8'd1, "conf_flash");
        pass_step(4'h1, 4'h0, 4'hE, 4'h2, 4'hD, 1'b1, 8'd1, "ack_clean");
        pass_step(4'h0, 4'h4, 4'hB, 4'h1, 4'hE, 1'b0, 8'd1, "after_ack");

        // E2 and E3 (and E4) together: lowest code 2 wins; later errors do not rewrite it
        pass_step(4'h1, 4'h0, 4'hF, 4'h1, 4'h1, 1'b0, 8'd1, "prio_1");
        pass_step(4'h1, 4'h0, 4'hF, 4'h1, 4'h1, 1'b0, 8'd1, "prio_2");
        flt_step(4'h1, 4'h0, 4'hF, 4'h1, 4'h1, 1'b0, 4'hF, 3'd2, 8'd2, "prio_entry");
        flt_step(4'h3, 4'h0, 4'hC, 4'h0, 4'hF, 1'b0, 4'hF, 3'd2, 8'd2, "prio_hold");
        pass_step(4'h1, 4'h0, 4'hE, 4'h2, 4'hD, 1'b1, 8'd2, "prio_ack");

        // Reset in SUSPECT clears the persistence count and the fault counter
        pass_step(4'h3, 4'h0, 4'hC, 4'h0, 4'hF, 1'b0, 8'd2, "susp_1");
        pass_step(4'h3, 4'h0, 4'hC, 4'h0, 4'hF, 1'b0, 8'd2, "susp_2");
        rst_step(4'h3, 4'h0, 4'hC, 4'h0, 4'hF, "susp_rst");
        pass_step(4'h3, 4'h0, 4'hC, 4'h0, 4'hF, 1'b0, 8'd0, "susp_re1");
        pass_step(4'h3, 4'h0, 4'hC, 4'h0, 4'hF, 1'b0, 8'd0, "susp_re2");
        flt_step(4'h3, 4'h0, 4'hC, 4'h0, 4'hF, 1'b0, 4'hF, 3'd1, 8'd1, "susp_re3");

        // Reset in FAULT
        rst_step(4'h3, 4'h0, 4'hC, 4'h0, 4'hF, "fault_rst");
        pass_step(4'h1, 4'h0, 4'hE, 4'h2, 4'hD, 1'b0, 8'd0, "fault_rst_after");

        // 256 fault/ack rounds saturate the entry counter at 255
        for (int i = 1; i <= 256; i++) begin
            nprev = (i - 1 > 255) ? 8'd255 : 8'(i - 1);
            ncur  = (i > 255) ? 8'd255 : 8'(i);
            pass_step(4'h3, 4'h0, 4'hC, 4'h0, 4'hF, 1'b0, nprev, "sat_s1");
            pass_step(4'h3, 4'h0, 4'hC, 4'h0, 4'hF, 1'b0, nprev, "sat_s2");
            flt_step(4'h3, 4'h0, 4'hC, 4'h0, 4'hF, 1'b0, 4'hF, 3'd1, ncur, "sat_fault");
            pass_step(4'h1, 4'h0, 4'hE, 4'h2, 4'hD, 1'b1, ncur, "sat_ack");
        end
        rst_step(4'h1, 4'h0, 4'hE, 4'h2, 4'hD, "final_rst");

        for (int i = 0; i < 20 && exp_q.size() != 0; i++)
            @(posedge clk);
        #3;
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: got %0d pending, want 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/monitor_conflicte.md
MONITOR_CONFLICTE -- requirements
Module: monitor_conflicte

Interface
REQ-001 Parameter FACTOR_DIVIZARE, default 1000: clock cycles per flash half-period in fault mode; legal range is 2 and above.
REQ-002 Parameter PERSISTENTA, default 3: consecutive clock cycles an error condition must hold before the fault latches; legal range is 1 to 255.
REQ-003 Port list: one clock; reset is synchronous and active-high.
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous reset, active-high
- verde_i  in  4  vehicle green per approach; bit0 nord, bit1 sud, bit2 est, bit3 vest (same bit order on every 4-bit port)
- galben_i  in  4  vehicle yellow per approach
- rosu_i  in  4  vehicle red per approach
- verde_pietoni_i  in  4  pedestrian green per approach
- rosu_pietoni_i  in  4  pedestrian red per approach
- ack_i  in  1  operator fault acknowledge, level-sampled
- verde_o, galben_o, rosu_o, verde_pietoni_o, rosu_pietoni_o  out  4 each  lamp drive to the field
- fault_o  out  1  monitor in FAULT state
- cod_fault_o  out  3  latched fault code
- nr_fault_o  out  8  count of FAULT entries, saturating

Function
REQ-004 Error conditions are evaluated combinationally every cycle on the raw inputs:
- E1: two or more verde_i bits set.
- E2: for any approach, the count of set bits among verde_i/galben_i/rosu_i is not exactly 1.
- E3: for any approach, verde_pietoni_i equals rosu_pietoni_i.
- E4: for any approach, verde_pietoni_i is set together with verde_i or galben_i.
REQ-005 Code assignment: E1=3'd1, E2=3'd2, E3=3'd3, E4=3'd4; when several conditions are active, the lowest code wins; 3'd0 means no fault.
REQ-006 The FSM has three states:
- NORMAL: reset state.
- SUSPECT: persistence counter cnt running.
- FAULT: latched fault.
REQ-007 NORMAL transitions:
- Any error active: go to SUSPECT with cnt=1, or directly to FAULT when PERSISTENTA=1.
- No error active: stay in NORMAL.
REQ-008 SUSPECT transitions:
- Error active and cnt==PERSISTENTA-1: go to FAULT.
- Error active otherwise: cnt increments.
- No error active: return to NORMAL and clear cnt.
REQ-009 The code latched on FAULT entry is the code computed in the entry cycle; it holds until FAULT is left.
REQ-010 FAULT exit: leave to NORMAL only when ack_i=1 and no error is active in the same cycle; otherwise ack_i is ignored and the state stays FAULT.
REQ-011 Output register contents in NORMAL and SUSPECT: all lamp outputs are the registered copy of the corresponding inputs, giving 1-cycle latency.
REQ-012 Output register contents in FAULT:
- verde_o=0, rosu_o=0, verde_pietoni_o=0, rosu_pietoni_o=4'hF.
- galben_o=4'hF or 4'h0, per the flash generator.
REQ-013 Flash generator:
- A divider counts 0..FACTOR_DIVIZARE-1 while in FAULT.
- The flash phase toggles at each divider wrap.
- On FAULT entry the divider clears and the phase is "on", so galben_o=4'hF on the first FAULT output cycle.
REQ-014 fault_o=1 and cod_fault_o=latched code exactly in the cycles where the state register is FAULT; otherwise fault_o=0 and cod_fault_o=0.
REQ-015 nr_fault_o increments by 1 on each NORMAL/SUSPECT-to-FAULT transition and holds at 8'd255.
REQ-016 Errors change neither the state nor the code while in FAULT.
REQ-017 Entering FAULT, SUSPECT-to-FAULT and NORMAL-to-FAULT alike, overrides the lamp outputs in the same edge the state becomes FAULT.

Reset
REQ-018 When rst=1 at a rising edge, the following take effect at that edge regardless of state or inputs:
- state=NORMAL, cnt=0, divider=0, nr_fault_o=0, fault_o=0, cod_fault_o=0.
- verde_o=0, galben_o=0, rosu_o=4'hF, verde_pietoni_o=0, rosu_pietoni_o=4'hF.
REQ-019 Reset in the middle of FAULT or SUSPECT discards the latched code and counters.

Verification (PERSISTENTA=3, FACTOR_DIVIZARE=4)
REQ-020 Glitch filter: verde_i=4'b0011 for 2 cycles, then legal inputs -> fault_o stays 0, nr_fault_o=0; outputs track inputs with 1-cycle delay.
REQ-021 Conflict: verde_i=4'b0011 held (rosu_i=4'b1100, galben_i=0) -> fault_o=1 at the 3rd edge, cod_fault_o=1, nr_fault_o=1; galben_o sequence F,F,F,F,0,0,0,0,F...; verde_o=0, rosu_pietoni_o=4'hF.
REQ-022 Priority: verde_i=4'b0001 with rosu_i=4'b1111 plus verde_pietoni_i=rosu_pietoni_i=4'b0001 for 3 cycles -> cod_fault_o=2, since E2 and E3 are both active.
REQ-023 Acknowledge: in FAULT, ack_i=1 while an error persists -> state stays FAULT; then clean inputs with ack_i=1 -> NORMAL next edge, fault_o=0, and lamps pass through with 1-cycle delay.
REQ-024 Saturation: force 256 FAULT/ack cycles -> nr_fault_o=255.
REQ-025 Reset: rst=1 during FAULT -> next edge: fault_o=0, cod_fault_o=0, nr_fault_o=0, rosu_o=4'hF, galben_o=0.
